// File: rtl/oops_mem_pkg.sv
// Shared widths, FSM state encoding and address helper for the burst line responder.
// Lines are LINE_W bits, moved to/from the host as BEATS beats of BEAT_W bits.
package oops_mem_pkg;
    localparam int BEAT_W      = 64;
    localparam int BEATS       = 4;
    localparam int LINE_W      = BEAT_W * BEATS;
    localparam int OFFSET_BITS = 5;
    localparam int CNT_W       = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        LINE_RD,
        BURST_RD,
        WR_COLLECT,
        LINE_WR,
        DONE
    } state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction
endpackage

// File: rtl/line_beat_buffer.sv
// Line register plus beat counter: loads a whole line, inserts beats at the counter slot,
// and presents the beat selected by the counter. Single-cycle updates, no flow control.
module line_beat_buffer import oops_mem_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_insert,
    input  logic              i_adv,
    input  logic [LINE_W-1:0] i_line,
    input  logic [BEAT_W-1:0] i_beat,
    output logic [CNT_W-1:0]  o_cnt,
    output logic [BEAT_W-1:0] o_beat,
    output logic [LINE_W-1:0] o_line
);
    logic [LINE_W-1:0] r_line;
    logic [CNT_W-1:0]  r_cnt;
    logic [BEAT_W-1:0] w_beat;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_line <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_load) begin
                r_line <= i_line;
            end else if (i_insert) begin
                for (int b = 0; b < BEATS; b++) begin
                    if (r_cnt == CNT_W'(b)) begin
                        r_line[b*BEAT_W +: BEAT_W] <= i_beat;
                    end
                end
            end
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_insert || i_adv) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_beat = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b)) begin
                w_beat = r_line[b*BEAT_W +: BEAT_W];
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_beat = w_beat;
    assign o_line = r_line;
endmodule

// File: rtl/burst_line_responder.sv
// Memory-side endpoint of the 4-beat burst protocol: reads fetch a full line then stream 4 beats,
// writes collect 4 beats then commit one line. Outputs decode registered state only.
module burst_line_responder import oops_mem_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              burst_read_i,
    input  logic              burst_write_i,
    input  logic [31:0]       burst_addr_i,
    input  logic [BEAT_W-1:0] burst_wdata_i,
    output logic [BEAT_W-1:0] burst_rdata_o,
    output logic              burst_resp_o,
    output logic              line_read_o,
    output logic              line_write_o,
    output logic [31:0]       line_addr_o,
    output logic [LINE_W-1:0] line_wdata_o,
    input  logic [LINE_W-1:0] line_rdata_i,
    input  logic              line_resp_i
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_addr;
    logic              w_latch_addr;
    logic              w_clr;
    logic              w_load;
    logic              w_insert;
    logic              w_adv;
    logic [CNT_W-1:0]  w_cnt;
    logic [BEAT_W-1:0] w_beat;
    logic [LINE_W-1:0] w_line;
    logic              w_last_beat;

    line_beat_buffer u_buf (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_load   (w_load),
        .i_insert (w_insert),
        .i_adv    (w_adv),
        .i_line   (line_rdata_i),
        .i_beat   (burst_wdata_i),
        .o_cnt    (w_cnt),
        .o_beat   (w_beat),
        .o_line   (w_line)
    );

    assign w_last_beat = (w_cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_addr) begin
                r_addr <= line_align(burst_addr_i);
            end
        end
    end

    // Read has priority over write when both are requested in IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_latch_addr = 1'b0;
        w_clr        = 1'b0;
        w_load       = 1'b0;
        w_insert     = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            IDLE: begin
                if (burst_read_i) begin
                    w_latch_addr = 1'b1;
                    w_state_nxt  = LINE_RD;
                end else if (burst_write_i) begin
                    w_latch_addr = 1'b1;
                    w_clr        = 1'b1;
                    w_state_nxt  = WR_COLLECT;
                end
            end
            LINE_RD: begin
                if (line_resp_i) begin
                    w_load      = 1'b1;
                    w_clr       = 1'b1;
                    w_state_nxt = BURST_RD;
                end
            end
            BURST_RD: begin
                w_adv = 1'b1;
                if (w_last_beat) w_state_nxt = DONE;
            end
            WR_COLLECT: begin
                w_insert = 1'b1;
                if (w_last_beat) w_state_nxt = LINE_WR;
            end
            LINE_WR: begin
                if (line_resp_i) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign burst_resp_o  = (r_state == BURST_RD) || (r_state == WR_COLLECT);
    assign burst_rdata_o = (r_state == BURST_RD) ? w_beat : '0;
    assign line_read_o   = (r_state == LINE_RD);
    assign line_write_o  = (r_state == LINE_WR);
    assign line_addr_o   = (line_read_o || line_write_o) ? r_addr : '0;
    assign line_wdata_o  = line_write_o ? w_line : '0;
endmodule

// File: tb/tb_burst_line_responder.sv
// Bench for burst_line_responder: directed cases plus random reads/writes against a
// line-level memory model with a behavioural backing store of random latency.
module tb_burst_line_responder;
    import oops_mem_pkg::*;

    logic              clk;
    logic              rst;
    logic              burst_read_i;
    logic              burst_write_i;
    logic [31:0]       burst_addr_i;
    logic [BEAT_W-1:0] burst_wdata_i;
    logic [BEAT_W-1:0] burst_rdata_o;
    logic              burst_resp_o;
    logic              line_read_o;
    logic              line_write_o;
    logic [31:0]       line_addr_o;
    logic [LINE_W-1:0] line_wdata_o;
    logic [LINE_W-1:0] line_rdata_i;
    logic              line_resp_i;

    burst_line_responder dut (
        .clk           (clk),
        .rst           (rst),
        .burst_read_i  (burst_read_i),
        .burst_write_i (burst_write_i),
        .burst_addr_i  (burst_addr_i),
        .burst_wdata_i (burst_wdata_i),
        .burst_rdata_o (burst_rdata_o),
        .burst_resp_o  (burst_resp_o),
        .line_read_o   (line_read_o),
        .line_write_o  (line_write_o),
        .line_addr_o   (line_addr_o),
        .line_wdata_o  (line_wdata_o),
        .line_rdata_i  (line_rdata_i),
        .line_resp_i   (line_resp_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int errors;

    // Model of the transaction in flight: 0 none, 1 read, 2 write.
    int          act;
    logic [31:0] exp_addr;
    logic [255:0] exp_line;
    int          run;
    bit          last_resp, last_lrd, last_lwr, last_lresp;
    logic [63:0] cap_beat [4];
    logic [31:0] cap_laddr;
    logic [255:0] cap_wline;

    logic [255:0] mem     [logic [31:0]];
    logic [255:0] ref_mem [logic [31:0]];
    int mem_lat;
    int wait_cnt;
    bit responded;
    bit spur_en;

    function automatic logic [255:0] dflt(input logic [31:0] a);
        return {a ^ 32'hdead_beef, ~a, a + 32'h1357_9bdf, a,
                a ^ 32'h0f0f_0f0f, a << 3, a * 32'd7, a ^ 32'h5a5a_a5a5};
    endfunction

    function automatic logic [255:0] ref_get(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [255:0] mem_get(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the transaction model.
    task automatic compare();
        last_resp  = burst_resp_o;
        last_lrd   = line_read_o;
        last_lwr   = line_write_o;
        last_lresp = line_resp_i;
        if (line_read_o === 1'b1) begin
            cap_laddr = line_addr_o;
            chk("line_read_expected", act == 1, 1);
            chk("line_read_addr", line_addr_o, exp_addr);
        end
        if (line_write_o === 1'b1) begin
            cap_laddr = line_addr_o;
            cap_wline = line_wdata_o;
            chk("line_write_expected", act == 2, 1);
            chk("line_write_addr", line_addr_o, exp_addr);
            chk("line_write_data", line_wdata_o, exp_line);
        end
        if (burst_resp_o === 1'b1) begin
            chk("resp_expected", act != 0, 1);
            chk("resp_run_max4", run < 4, 1);
            if (run < 4 && act == 1) begin
                cap_beat[run] = burst_rdata_o;
                chk("read_beat", burst_rdata_o, exp_line[64*run +: 64]);
            end
            run++;
        end else begin
            run = 0;
        end
    endtask

    task automatic store_model();
        if (line_read_o || line_write_o) begin
            if (responded) begin
                line_resp_i = 1'b0;
                responded   = 1'b0;
                wait_cnt    = 0;
            end else if (wait_cnt >= mem_lat) begin
                line_resp_i = 1'b1;
                responded   = 1'b1;
                wait_cnt    = 0;
                if (line_read_o) line_rdata_i = mem_get(line_addr_o);
                else             mem[line_addr_o] = line_wdata_o;
            end else begin
                line_resp_i = 1'b0;
                wait_cnt++;
            end
        end else begin
            responded    = 1'b0;
            wait_cnt     = 0;
            line_resp_i  = spur_en && ($urandom_range(0, 2) == 0);
            line_rdata_i = {8{$urandom}};
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        store_model();
    endtask

    task automatic rd_setup(input logic [31:0] a, input int lat, input bit both);
        act           = 1;
        exp_addr      = line_align(a);
        exp_line      = ref_get(exp_addr);
        mem_lat       = lat;
        burst_addr_i  = a;
        burst_read_i  = 1'b1;
        burst_write_i = both;
        burst_wdata_i = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) cap_beat[i] = '0;
    endtask

    task automatic rd_loop(input int target);
        int n, beats, first, last;
        n = 0; beats = 0; first = -1; last = -1;
        while (beats < target && n < 300) begin
            step();
            n++;
            if (last_resp) begin
                if (first < 0) first = n;
                last = n;
                beats++;
            end
        end
        chk("read_beats_seen", beats, target);
        if (beats == target) chk("read_beats_consecutive", last - first, target - 1);
    endtask

    task automatic rd_done();
        act           = 0;
        burst_read_i  = 1'b0;
        burst_write_i = 1'b0;
        step();
        chk("done_cycle_quiet", {last_resp, last_lrd, last_lwr}, 3'b000);
    endtask

    task automatic do_read(input logic [31:0] a, input int lat, input bit both);
        rd_setup(a, lat, both);
        rd_loop(4);
        rd_done();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3, input int lat);
        logic [63:0] b [4];
        int n, k, first, last;
        bit done;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        act           = 2;
        exp_addr      = line_align(a);
        exp_line      = {b3, b2, b1, b0};
        ref_mem[exp_addr] = exp_line;
        mem_lat       = lat;
        burst_addr_i  = a;
        burst_read_i  = 1'b0;
        burst_write_i = 1'b1;
        burst_wdata_i = b0;
        cap_wline     = '0;
        n = 0; k = 0; first = -1; last = -1; done = 0;
        while (!done && n < 300) begin
            step();
            n++;
            if (last_resp && k < 4) begin
                if (k == 0) first = n;
                last = n;
                k++;
                if (k < 4) begin
                    burst_wdata_i = b[k];
                end else begin
                    burst_wdata_i = {$urandom, $urandom};
                    burst_write_i = 1'b0;
                end
            end
            if (last_lwr && last_lresp) done = 1;
        end
        burst_write_i = 1'b0;
        chk("write_beats_accepted", k, 4);
        chk("write_line_committed", done, 1);
        if (k == 4) chk("write_beats_consecutive", last - first, 3);
        act = 0;
        step();
        chk("done_cycle_quiet", {last_resp, last_lrd, last_lwr}, 3'b000);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_burst_resp"},  burst_resp_o, 0);
        chk({nm, "_line_read"},   line_read_o, 0);
        chk({nm, "_line_write"},  line_write_o, 0);
        chk({nm, "_line_addr"},   line_addr_o, 0);
        chk({nm, "_line_wdata"},  line_wdata_o, 0);
        chk({nm, "_burst_rdata"}, burst_rdata_o, 0);
    endtask

    initial begin
        logic [255:0] pat;
        checks = 0; errors = 0;
        act = 0; run = 0; mem_lat = 0; wait_cnt = 0; responded = 0; spur_en = 0;
        exp_addr = '0; exp_line = '0; cap_laddr = '0; cap_wline = '0;
        rst = 1'b0; burst_read_i = 1'b0; burst_write_i = 1'b0;
        burst_addr_i = '0; burst_wdata_i = '0; line_rdata_i = '0; line_resp_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        step();

        // Read of a preloaded line, store answering after 3 wait cycles.
        pat = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
        mem[32'h0000_1220]     = pat;
        ref_mem[32'h0000_1220] = pat;
        do_read(32'h0000_1234, 3, 0);
        chk("lit_read_addr",  cap_laddr,   32'h0000_1220);
        chk("lit_read_beat0", cap_beat[0], 64'h1111_1111_1111_1111);
        chk("lit_read_beat1", cap_beat[1], 64'h2222_2222_2222_2222);
        chk("lit_read_beat2", cap_beat[2], 64'h3333_3333_3333_3333);
        chk("lit_read_beat3", cap_beat[3], 64'h4444_4444_4444_4444);

        do_write(32'h0000_8000, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 1);
        chk("lit_write_addr", cap_laddr, 32'h0000_8000);
        chk("lit_write_line", cap_wline, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

        // Read back the same line through the store.
        do_read(32'h0000_8010, 0, 0);
        chk("lit_readback_beat2", cap_beat[2], 64'hA2);

        // Read and write together: read wins, no line write.
        spur_en = 1;
        do_read(32'h0000_1234, 2, 1);
        chk("lit_both_beat3", cap_beat[3], 64'h4444_4444_4444_4444);

        // Back-to-back: request held through DONE is taken only in the next IDLE cycle.
        rd_setup(32'h0000_1234, 0, 0);
        rd_loop(4);
        act = 0;
        burst_addr_i = 32'h0000_8004;
        step();
        chk("b2b_done_quiet", {last_resp, last_lrd, last_lwr}, 3'b000);
        step();
        chk("b2b_not_taken_in_done", last_lrd, 0);
        chk("b2b_taken_next_cycle", line_read_o, 1);
        act      = 1;
        exp_addr = line_align(32'h0000_8004);
        exp_line = ref_get(exp_addr);
        rd_loop(4);
        rd_done();
        chk("lit_b2b_beat1", cap_beat[1], 64'hA1);

        // Reset after two beats of a read, then a fresh read.
        rd_setup(32'h0000_1234, 1, 0);
        rd_loop(2);
        rst = 1'b0; burst_read_i = 1'b0; act = 0;
        @(posedge clk);
        #1;
        chk_all_zero("midreset");
        rst = 1'b1;
        line_resp_i = 1'b0;
        step();
        do_read(32'h0000_1234, 2, 0);
        chk("lit_after_reset_beat0", cap_beat[0], 64'h1111_1111_1111_1111);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int op, lat;
            a   = 32'h0000_4000 + (32'($urandom_range(0, 7)) << 5) + 32'($urandom_range(0, 31));
            op  = $urandom_range(0, 2);
            lat = $urandom_range(0, 4);
            spur_en = ($urandom_range(0, 1) == 1);
            if (op == 1) begin
                do_write(a, {$urandom, $urandom}, {$urandom, $urandom},
                         {$urandom, $urandom}, {$urandom, $urandom}, lat);
            end else begin
                do_read(a, lat, op == 2);
            end
            repeat ($urandom_range(0, 2)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/burst_line_responder.md
Name: burst_line_responder

Overview:
- Memory-side endpoint of the 64-bit, 4-beat burst protocol driven by the cache line adaptor toward physical memory.
- Accepts burst reads and writes.
- Serves a read by fetching one full 256-bit line from a line-wide backing store, then streaming it out as four beats.
- Serves a write by collecting four beats into a line, then committing that line to the backing store in a single access.

Parameters:
- BEAT_W, 64, width of one burst beat.
- BEATS, 4, beats per cache line.
- LINE_W, BEAT_W*BEATS (256), width of one cache line.

Ports:
- clk  input  1  clock; everything samples on the rising edge.
- rst  input  1  synchronous, active-low reset.
- burst_read_i  input  1  burst read request; host holds it until the last beat is delivered.
- burst_write_i  input  1  burst write request; host holds it until the last beat is accepted.
- burst_addr_i  input  32  request byte address; bits [4:0] are ignored.
- burst_wdata_i  input  BEAT_W  write beat currently presented by the host.
- burst_rdata_o  output  BEAT_W  read beat; valid when burst_resp_o=1 during a read.
- burst_resp_o  output  1  one pulse per transferred beat.
- line_read_o  output  1  backing-store line read request.
- line_write_o  output  1  backing-store line write request.
- line_addr_o  output  32  line-aligned backing-store address.
- line_wdata_o  output  LINE_W  assembled write line.
- line_rdata_i  input  LINE_W  backing-store read line.
- line_resp_i  input  1  backing-store completion, one cycle.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE and the beat counter clears.
  - All outputs are 0: burst_resp_o, line_read_o, line_write_o, line_addr_o, line_wdata_o, burst_rdata_o.
  - Reset mid-operation abandons the transfer: partial beats are discarded and any pending line request drops the next cycle.
- All outputs are decoded from registered state and data, so no input-to-output combinational path exists.
- States:
  - IDLE:
    - burst_read_i=1 latches line address {burst_addr_i[31:5],5'b0}, then goes to LINE_RD.
    - Otherwise burst_write_i=1 latches the address, clears the counter, then goes to WR_COLLECT.
    - If read and write are both high, read wins.
  - LINE_RD:
    - line_read_o=1 and line_addr_o=latched address.
    - On line_resp_i=1: capture line_rdata_i, clear the counter, go to BURST_RD.
    - No timeout; waits indefinitely.
  - BURST_RD:
    - burst_resp_o=1 and burst_rdata_o=line[BEAT_W*cnt +: BEAT_W], with beat 0 = bits [63:0].
    - cnt increments every cycle; after cnt=3 go to DONE.
    - Exactly 4 consecutive resp cycles, no bubbles.
  - WR_COLLECT:
    - burst_resp_o=1.
    - At each edge, burst_wdata_i is stored into slot cnt and cnt increments.
    - After storing cnt=3, go to LINE_WR.
    - The host changes burst_wdata_i only after seeing resp.
  - LINE_WR:
    - line_write_o=1, line_addr_o=latched address, line_wdata_o=assembled line.
    - On line_resp_i=1 go to DONE.
  - DONE:
    - One cycle with all requests and resp at 0, then IDLE.
    - Gives the host a cycle to drop its request, so a held request is never re-accepted as a new transfer.
- Latency:
  - Read: request sampled at edge 0, line_read_o high from cycle 1; if line_resp_i=1 in cycle 1, beats appear in cycles 2–5.
  - Write: beats accepted in cycles 1–4, line_write_o from cycle 5.
  - Busy until DONE.
- Protocol violations:
  - A request dropped while busy is ignored; the transfer completes.
  - line_resp_i outside LINE_RD/LINE_WR is ignored.
- The counter is 2 bits and cannot wrap mid-burst, because state exits at cnt=3.

Decomposition:
- Package oops_mem_pkg holds:
  - BEAT_W, BEATS, LINE_W, OFFSET_BITS (5).
  - State enum {IDLE, LINE_RD, BURST_RD, WR_COLLECT, LINE_WR, DONE}.
  - Function line_align(addr).
- One sub-module, line_beat_buffer, owns the LINE_W register, the beat counter, and the beat-select/beat-insert logic.
- The FSM stays in burst_line_responder.

Test Plan:
- Read at burst_addr_i=0x0000_1234, backing store returns line_resp_i after 3 cycles with line 0x4444…_3333…_2222…_1111… -> line_addr_o=0x0000_1220; four consecutive resp beats 0x1111…, 0x2222…, 0x3333…, 0x4444…; then one idle cycle.
- Write at 0x0000_8000 with beats 0xA0, 0xA1, 0xA2, 0xA3 -> 4 resp pulses, then line_write_o=1, line_addr_o=0x0000_8000, line_wdata_o={0xA3,0xA2,0xA1,0xA0} (each zero-extended to 64 bits).
- Read and write asserted together in IDLE -> read path taken; line_write_o stays 0.
- Back-to-back: host re-asserts read immediately after the last beat -> the new request is not accepted in DONE; it is accepted the following cycle.
- rst=0 during BURST_RD after 2 beats, then rst=1 -> all outputs 0; next request starts a fresh transfer with beat 0 first.
- Write followed by read to the same line, using a behavioural backing store -> read returns the written beats unchanged.
